// File: rtl/regfile_exec_ctrl.sv
// regfile_exec_ctrl
// Initiator for a 2-entry register file (s0/s1). It accepts one 8-bit
// instruction at a time over a valid/ready handshake. It reads the source
// registers, evaluates the ALU operation and writes the result back through
// the file's write port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only while idle)
//   instr[7:0]               [7:5] opcode, [4] rd (dest/src1), [3] rs, [2:0] imm3
//   rf_rd_addr1/2            read addresses (rd, rs), held for the whole op
//   rf_rdata1/2              read data, valid READ_LAT cycles after address
//   rf_wr_addr/data/en       write port, rf_wr_en is a one-cycle strobe
//   done, illegal            retire pulse; illegal also pulses for opcode 111
//   result, carry, zero      last computed value and ALU flags
module regfile_exec_ctrl #(
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr,
    output logic              rf_rd_addr1,
    output logic              rf_rd_addr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              rf_wr_en,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              illegal
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MOV  = 3'b100,
        OP_ADDI = 3'b101,
        OP_AND  = 3'b110,
        OP_ILL  = 3'b111
    } op_e;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

    state_e            state;
    logic [1:0]        cnt;
    logic [7:0]        ir;
    op_e               op;
    logic [DATA_W:0]   alu;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_z;
    logic              writes_rf;
    logic              updates_flags;

    assign op          = op_e'(ir[7:5]);
    assign instr_ready = (state == IDLE);

    assign writes_rf     = (op != OP_NOP) && (op != OP_ILL);
    assign updates_flags = (op == OP_ADD) || (op == OP_SUB) ||
                           (op == OP_ADDI) || (op == OP_AND);

    // One extra bit captures carry out of ADD/ADDI and borrow out of SUB.
    always_comb begin
        logic [DATA_W:0] a, b, imm;
        a   = {1'b0, rf_rdata1};
        b   = {1'b0, rf_rdata2};
        imm = {{(DATA_W-2){1'b0}}, ir[2:0]};
        alu = '0;
        case (op)
            OP_LDI:  alu = imm;
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_MOV:  alu = b;
            OP_ADDI: alu = a + imm;
            OP_AND:  alu = a & b;
            default: alu = '0;
        endcase
    end

    // The write strobe, done and the visible result/flags are registered on
    // the edge leaving WB, so they appear together in the cycle after WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ir          <= '0;
            alu_res     <= '0;
            alu_c       <= 1'b0;
            alu_z       <= 1'b0;
            rf_rd_addr1 <= 1'b0;
            rf_rd_addr2 <= 1'b0;
            rf_wr_addr  <= 1'b0;
            rf_wr_data  <= '0;
            rf_wr_en    <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            rf_wr_en <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir          <= instr;
                        rf_rd_addr1 <= instr[4];
                        rf_rd_addr2 <= instr[3];
                        cnt         <= 2'(READ_LAT);
                        state       <= READ;
                    end
                end
                READ: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) state <= EXEC;
                end
                EXEC: begin
                    alu_res <= alu[DATA_W-1:0];
                    alu_c   <= alu[DATA_W];
                    alu_z   <= (alu[DATA_W-1:0] == '0);
                    state   <= WB;
                end
                WB: begin
                    done    <= 1'b1;
                    illegal <= (op == OP_ILL);
                    if (writes_rf) begin
                        rf_wr_en   <= 1'b1;
                        rf_wr_addr <= ir[4];
                        rf_wr_data <= alu_res;
                        result     <= alu_res;
                    end
                    if (updates_flags) begin
                        carry <= alu_c;
                        zero  <= alu_z;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_exec_ctrl.sv
// Testbench for regfile_exec_ctrl: instance a uses READ_LAT=1 and instance b
// uses READ_LAT=3. Each instance has its own behavioural register file with
// matching read latency.
module tb_regfile_exec_ctrl;

    typedef struct {
        int         due;
        logic       wen;
        logic       waddr;
        logic [7:0] wdata;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int tests = 0;
    int fails = 0;

    exp_t qa[$];
    exp_t qb[$];

    // instance a (READ_LAT=1)
    logic       va, ra, a_addr1, a_addr2, a_waddr, a_wen, a_done, a_c, a_z, a_ill;
    logic [7:0] ia, a_rd1, a_rd2, a_wdata, a_res;
    // instance b (READ_LAT=3)
    logic       vb, rb, b_addr1, b_addr2, b_waddr, b_wen, b_done, b_c, b_z, b_ill;
    logic [7:0] ib, b_rd1, b_rd2, b_wdata, b_res;

    regfile_exec_ctrl #(.DATA_W(8), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .instr_valid(va), .instr_ready(ra), .instr(ia),
        .rf_rd_addr1(a_addr1), .rf_rd_addr2(a_addr2),
        .rf_rdata1(a_rd1), .rf_rdata2(a_rd2),
        .rf_wr_addr(a_waddr), .rf_wr_data(a_wdata), .rf_wr_en(a_wen),
        .done(a_done), .result(a_res), .carry(a_c), .zero(a_z), .illegal(a_ill)
    );

    regfile_exec_ctrl #(.DATA_W(8), .READ_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .instr_valid(vb), .instr_ready(rb), .instr(ib),
        .rf_rd_addr1(b_addr1), .rf_rd_addr2(b_addr2),
        .rf_rdata1(b_rd1), .rf_rdata2(b_rd2),
        .rf_wr_addr(b_waddr), .rf_wr_data(b_wdata), .rf_wr_en(b_wen),
        .done(b_done), .result(b_res), .carry(b_c), .zero(b_z), .illegal(b_ill)
    );

    // Register file models; the bench preloads through ld_* when idle.
    logic [7:0] mem_a [2];
    logic [7:0] mem_b [2];
    logic [7:0] pa1, pa2;
    logic [7:0] pb1 [3];
    logic [7:0] pb2 [3];
    logic       ld_a, ld_b, ld_addr;
    logic [7:0] ld_data;

    always @(posedge clk) begin
        if (a_wen)     mem_a[a_waddr] <= a_wdata;
        else if (ld_a) mem_a[ld_addr] <= ld_data;
        pa1 <= mem_a[a_addr1];
        pa2 <= mem_a[a_addr2];
    end
    assign a_rd1 = pa1;
    assign a_rd2 = pa2;

    always @(posedge clk) begin
        if (b_wen)     mem_b[b_waddr] <= b_wdata;
        else if (ld_b) mem_b[ld_addr] <= ld_data;
        pb1[0] <= mem_b[b_addr1];
        pb2[0] <= mem_b[b_addr2];
        pb1[1] <= pb1[0];
        pb2[1] <= pb2[0];
        pb1[2] <= pb1[1];
        pb2[2] <= pb2[1];
    end
    assign b_rd1 = pb1[2];
    assign b_rd2 = pb2[2];

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic retire_check(input string tag, input exp_t e, input logic wen,
                                input logic waddr, input logic [7:0] wdata,
                                input logic [7:0] res, input logic c, input logic z,
                                input logic ill);
        chk({tag, "_done_cycle"}, cycle, e.due);
        chk({tag, "_wr_en"}, int'(wen), int'(e.wen));
        if (e.wen) begin
            chk({tag, "_wr_addr"}, int'(waddr), int'(e.waddr));
            chk({tag, "_wr_data"}, int'(wdata), int'(e.wdata));
        end
        chk({tag, "_result"}, int'(res), int'(e.res));
        chk({tag, "_carry"}, int'(c), int'(e.c));
        chk({tag, "_zero"}, int'(z), int'(e.z));
        chk({tag, "_illegal"}, int'(ill), int'(e.ill));
    endtask

    // Monitor: pops an expectation on every done pulse.
    exp_t ea, eb;
    always @(negedge clk) begin
        if (!rst) begin
            if (a_done) begin
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_unexpected_done: got done=1, expected none at cycle %0d", cycle);
                end else begin
                    ea = qa.pop_front();
                    retire_check("a", ea, a_wen, a_waddr, a_wdata, a_res, a_c, a_z, a_ill);
                end
            end else if (a_wen || a_ill) begin
                tests++; fails++;
                $display("FAIL a_strobe_without_done: got wr_en=%0d illegal=%0d, expected 0", a_wen, a_ill);
            end
            if (b_done) begin
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected_done: got done=1, expected none at cycle %0d", cycle);
                end else begin
                    eb = qb.pop_front();
                    retire_check("b", eb, b_wen, b_waddr, b_wdata, b_res, b_c, b_z, b_ill);
                end
            end else if (b_wen || b_ill) begin
                tests++; fails++;
                $display("FAIL b_strobe_without_done: got wr_en=%0d illegal=%0d, expected 0", b_wen, b_ill);
            end
        end
    end

    function automatic exp_t mk(input logic wen, input logic waddr, input logic [7:0] wdata,
                                input logic [7:0] res, input logic c, input logic z,
                                input logic ill);
        exp_t e;
        e.due = 0; e.wen = wen; e.waddr = waddr; e.wdata = wdata;
        e.res = res; e.c = c; e.z = z; e.ill = ill;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit sel_b, input logic [7:0] ins, input exp_t e,
                         input bit push, output int acc);
        int n;
        exp_t x;
        x = e;
        n = 0;
        if (sel_b) begin ib = ins; vb = 1'b1; end
        else begin ia = ins; va = 1'b1; end
        while (!(sel_b ? rb : ra) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(sel_b ? rb : ra)) begin
            tests++; fails++;
            $display("FAIL %s_accept_timeout: got ready=0, expected 1", sel_b ? "b" : "a");
            acc = -1;
        end else begin
            acc   = cycle + 1;
            x.due = acc + (sel_b ? 3 : 1) + 2;
            if (push) begin
                if (sel_b) qb.push_back(x);
                else qa.push_back(x);
            end
        end
        @(negedge clk);
        if (sel_b) vb = 1'b0;
        else va = 1'b0;
    endtask

    task automatic count_busy(input bit sel_b, output int n);
        n = 0;
        while (!(sel_b ? rb : ra) && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Waits until every expected retire has been seen and its write landed.
    task automatic wait_idle();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            tests++; fails++;
            $display("FAIL retire_timeout: got %0d/%0d pending, expected 0", qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        @(negedge clk);
    endtask

    task automatic preload(input bit sel_b, input logic addr, input logic [7:0] data);
        ld_addr = addr; ld_data = data;
        if (sel_b) ld_b = 1'b1; else ld_a = 1'b1;
        @(negedge clk);
        ld_a = 1'b0; ld_b = 1'b0;
    endtask

    initial begin
        int acc1, acc2, n;
        logic [27:0] outs;
        rst = 1'b1; va = 1'b0; vb = 1'b0; ia = '0; ib = '0;
        ld_a = 1'b0; ld_b = 1'b0; ld_addr = 1'b0; ld_data = '0;
        repeat (2) @(negedge clk);

        outs = {a_addr1, a_addr2, a_waddr, a_wdata, a_wen, a_done, a_res, a_c, a_z, a_ill};
        chk("reset_outputs_a", int'(outs), 0);
        chk("reset_ready_a", int'(ra), 1);
        chk("reset_ready_b", int'(rb), 1);
        rst = 1'b0;
        @(negedge clk);

        // ADD rd=0 rs=1: 4+3
        preload(0, 1'b0, 8'd4); preload(0, 1'b1, 8'd3);
        issue(0, 8'h48, mk(1, 0, 8'h07, 8'h07, 0, 0, 0), 1, acc1);
        wait_idle();

        // SUB rd=1 rs=0: 3-4 borrows
        preload(0, 1'b0, 8'd4);
        issue(0, 8'h70, mk(1, 1, 8'hFF, 8'hFF, 1, 0, 0), 1, acc1);
        wait_idle();

        // LDI s0=7 then dependent ADD s0+s0, back-to-back; flags kept by LDI
        issue(0, 8'h27, mk(1, 0, 8'h07, 8'h07, 1, 0, 0), 1, acc1);
        count_busy(0, n);
        chk("a_busy_cycles", n, 3);
        issue(0, 8'h40, mk(1, 0, 8'h0E, 8'h0E, 0, 0, 0), 1, acc2);
        chk("a_issue_interval", acc2 - acc1, 4);
        wait_idle();

        // ADDI wraps 0xFF+1, then illegal leaves flags and result alone
        preload(0, 1'b0, 8'hFF);
        issue(0, 8'hA1, mk(1, 0, 8'h00, 8'h00, 1, 1, 0), 1, acc1);
        count_busy(0, n);
        issue(0, 8'hE0, mk(0, 0, 8'h00, 8'h00, 1, 1, 1), 1, acc1);
        wait_idle();

        // AND clears carry; MOV and NOP keep flags
        preload(0, 1'b0, 8'h0C); preload(0, 1'b1, 8'h0A);
        issue(0, 8'hC8, mk(1, 0, 8'h08, 8'h08, 0, 0, 0), 1, acc1);
        wait_idle();
        issue(0, 8'h90, mk(1, 1, 8'h08, 8'h08, 0, 0, 0), 1, acc1);
        wait_idle();
        issue(0, 8'h00, mk(0, 0, 8'h00, 8'h08, 0, 0, 0), 1, acc1);
        wait_idle();

        // rd==rs: SUB gives zero, ADD doubles with carry out
        preload(0, 1'b1, 8'h05);
        issue(0, 8'h78, mk(1, 1, 8'h00, 8'h00, 0, 1, 0), 1, acc1);
        wait_idle();
        preload(0, 1'b1, 8'h81);
        issue(0, 8'h58, mk(1, 1, 8'h02, 8'h02, 1, 0, 0), 1, acc1);
        wait_idle();

        // Reset during READ aborts the ADD: no write, no done
        preload(0, 1'b0, 8'd4); preload(0, 1'b1, 8'd3);
        issue(0, 8'h48, mk(0, 0, 8'h00, 8'h00, 0, 0, 0), 0, acc1);
        rst = 1'b1;
        @(negedge clk);
        outs = {a_addr1, a_addr2, a_waddr, a_wdata, a_wen, a_done, a_res, a_c, a_z, a_ill};
        chk("midop_reset_outputs_a", int'(outs), 0);
        chk("midop_reset_ready_a", int'(ra), 1);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midop_reset_s0_kept", int'(mem_a[0]), 4);

        // READ_LAT=3: ADD 4+3, valid toggled while busy must be ignored
        preload(1, 1'b0, 8'd4); preload(1, 1'b1, 8'd3);
        issue(1, 8'h48, mk(1, 0, 8'h07, 8'h07, 0, 0, 0), 1, acc1);
        n = 0;
        while (!rb && n < 20) begin
            ib = 8'h40;
            vb = (n % 2 == 0);
            n++;
            @(negedge clk);
        end
        vb = 1'b0;
        chk("b_busy_cycles", n, 5);
        wait_idle();
        repeat (6) @(negedge clk);
        chk("b_s0_written", int'(mem_b[0]), 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
